// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data memory arbiter.
// Transaction state, owner encoding and wait-counter width.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

    localparam int CNT_W  = 3;
    localparam int DATA_W = 32;
    localparam int BE_W   = 4;

    typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Fetch, writeback and memory-macro signals seen by the arbiter.
// Suffixes are from the arbiter's point of view; master is the requester/memory side.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32
);
    import mem_arb_pkg::*;

    logic              imem_req_i;
    logic [ADDR_W-1:0] imem_addr_i;
    logic              imem_ready_o;
    logic [DATA_W-1:0] imem_rdata_o;
    logic              imem_valid_o;

    logic              dmem_req_i;
    logic              dmem_we_i;
    logic [ADDR_W-1:0] dmem_addr_i;
    logic [DATA_W-1:0] dmem_wdata_i;
    logic [BE_W-1:0]   dmem_be_i;
    logic              dmem_ready_o;
    logic [DATA_W-1:0] dmem_rdata_o;
    logic              dmem_valid_o;

    logic              mem_en_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic [BE_W-1:0]   mem_be_o;
    logic [DATA_W-1:0] mem_rdata_i;

    modport slave (
        input  imem_req_i, imem_addr_i,
        output imem_ready_o, imem_rdata_o, imem_valid_o,
        input  dmem_req_i, dmem_we_i, dmem_addr_i, dmem_wdata_i, dmem_be_i,
        output dmem_ready_o, dmem_rdata_o, dmem_valid_o,
        output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o,
        input  mem_rdata_i
    );

    modport master (
        output imem_req_i, imem_addr_i,
        input  imem_ready_o, imem_rdata_o, imem_valid_o,
        output dmem_req_i, dmem_we_i, dmem_addr_i, dmem_wdata_i, dmem_be_i,
        input  dmem_ready_o, dmem_rdata_o, dmem_valid_o,
        input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o,
        output mem_rdata_i
    );

endinterface

// File: rtl/arb_rr2.sv
// Two-requester grant: data wins unless it won last time and fetch is also asking.
// Combinational grant, last-winner register updates only on the advance strobe.
module arb_rr2
    import mem_arb_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic req_ins_i,
    input  logic req_dat_i,
    input  logic adv_i,
    output logic gnt_ins_o,
    output logic gnt_dat_o
);

    owner_e last_q;
    owner_e last_d;

    always_comb begin
        gnt_dat_o = req_dat_i & (~req_ins_i | (last_q == OWN_I));
        gnt_ins_o = req_ins_i & ~gnt_dat_o;
        last_d    = last_q;
        if (adv_i) begin
            last_d = gnt_dat_o ? OWN_D : OWN_I;
        end
    end

    // Reset to "fetch won last" so the first conflict goes to data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q <= OWN_I;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between fetch and writeback, one transaction at a time.
// Read: ISSUE, LATENCY wait cycles, one-cycle valid; write: ISSUE then valid; ready only in IDLE.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int LATENCY = 2,
    parameter int ADDR_W  = 32
) (
    input  logic         clk,
    input  logic         reset,
    mem_arbiter_if.slave bus
);

    state_e            state_q,  state_d;
    cnt_t              cnt_q,    cnt_d;
    owner_e            owner_q,  owner_d;
    logic [ADDR_W-1:0] addr_q,   addr_d;
    logic              we_q,     we_d;
    logic [DATA_W-1:0] wdata_q,  wdata_d;
    logic [BE_W-1:0]   be_q,     be_d;
    logic [DATA_W-1:0] irdata_q, irdata_d;
    logic [DATA_W-1:0] drdata_q, drdata_d;

    logic gnt_ins;
    logic gnt_dat;
    logic is_idle;
    logic is_issue;
    logic is_resp;
    logic accept;

    assign is_idle  = (state_q == IDLE);
    assign is_issue = (state_q == ISSUE);
    assign is_resp  = (state_q == RESP);
    assign accept   = is_idle & (gnt_ins | gnt_dat);

    arb_rr2 u_arb (
        .clk       (clk),
        .reset     (reset),
        .req_ins_i (bus.imem_req_i),
        .req_dat_i (bus.dmem_req_i),
        .adv_i     (accept),
        .gnt_ins_o (gnt_ins),
        .gnt_dat_o (gnt_dat)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            owner_q  <= OWN_I;
            addr_q   <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            be_q     <= '0;
            irdata_q <= '0;
            drdata_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            owner_q  <= owner_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
            be_q     <= be_d;
            irdata_q <= irdata_d;
            drdata_q <= drdata_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        owner_d  = owner_q;
        addr_d   = addr_q;
        we_d     = we_q;
        wdata_d  = wdata_q;
        be_d     = be_q;
        irdata_d = irdata_q;
        drdata_d = drdata_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    owner_d = gnt_dat ? OWN_D : OWN_I;
                    addr_d  = gnt_dat ? bus.dmem_addr_i : bus.imem_addr_i;
                    // Fetch is read-only, so its write fields are forced to zero.
                    we_d    = gnt_dat & bus.dmem_we_i;
                    wdata_d = gnt_dat ? bus.dmem_wdata_i : '0;
                    be_d    = gnt_dat ? bus.dmem_be_i : '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (we_q) begin
                    state_d = RESP;
                end else begin
                    cnt_d   = CNT_W'(LATENCY);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - cnt_t'(1);
                if (cnt_q == cnt_t'(1)) begin
                    if (owner_q == OWN_D) begin
                        drdata_d = bus.mem_rdata_i;
                    end else begin
                        irdata_d = bus.mem_rdata_i;
                    end
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.imem_ready_o = is_idle & gnt_ins;
    assign bus.dmem_ready_o = is_idle & gnt_dat;
    assign bus.imem_valid_o = is_resp & (owner_q == OWN_I);
    assign bus.dmem_valid_o = is_resp & (owner_q == OWN_D);
    assign bus.imem_rdata_o = irdata_q;
    assign bus.dmem_rdata_o = drdata_q;

    // Memory buses are driven only in the ISSUE cycle and idle at zero otherwise.
    assign bus.mem_en_o    = is_issue;
    assign bus.mem_we_o    = is_issue & we_q;
    assign bus.mem_addr_o  = is_issue ? addr_q  : '0;
    assign bus.mem_wdata_o = is_issue ? wdata_q : '0;
    assign bus.mem_be_o    = is_issue ? be_q    : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter at LATENCY 2, 4 and 1.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(32)) a2 ();
    mem_arbiter_if #(.ADDR_W(32)) a4 ();
    mem_arbiter_if #(.ADDR_W(32)) a1 ();

    mem_arbiter #(.LATENCY(2), .ADDR_W(32)) dut2 (.clk(clk), .reset(rst), .bus(a2.slave));
    mem_arbiter #(.LATENCY(4), .ADDR_W(32)) dut4 (.clk(clk), .reset(rst), .bus(a4.slave));
    mem_arbiter #(.LATENCY(1), .ADDR_W(32)) dut1 (.clk(clk), .reset(rst), .bus(a1.slave));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all;
        a2.imem_req_i = 0; a2.imem_addr_i = '0; a2.dmem_req_i = 0; a2.dmem_we_i = 0;
        a2.dmem_addr_i = '0; a2.dmem_wdata_i = '0; a2.dmem_be_i = '0; a2.mem_rdata_i = '0;
        a4.imem_req_i = 0; a4.imem_addr_i = '0; a4.dmem_req_i = 0; a4.dmem_we_i = 0;
        a4.dmem_addr_i = '0; a4.dmem_wdata_i = '0; a4.dmem_be_i = '0; a4.mem_rdata_i = '0;
        a1.imem_req_i = 0; a1.imem_addr_i = '0; a1.dmem_req_i = 0; a1.dmem_we_i = 0;
        a1.dmem_addr_i = '0; a1.dmem_wdata_i = '0; a1.dmem_be_i = '0; a1.mem_rdata_i = '0;
    endtask

    task automatic test_reset;
        logic [172:0] v2, v4, v1;
        rst = 1'b1;
        idle_all();
        #3;
        v2 = {a2.imem_ready_o, a2.imem_rdata_o, a2.imem_valid_o, a2.dmem_ready_o, a2.dmem_rdata_o,
              a2.dmem_valid_o, a2.mem_en_o, a2.mem_we_o, a2.mem_addr_o, a2.mem_wdata_o, a2.mem_be_o};
        v4 = {a4.imem_ready_o, a4.imem_rdata_o, a4.imem_valid_o, a4.dmem_ready_o, a4.dmem_rdata_o,
              a4.dmem_valid_o, a4.mem_en_o, a4.mem_we_o, a4.mem_addr_o, a4.mem_wdata_o, a4.mem_be_o};
        v1 = {a1.imem_ready_o, a1.imem_rdata_o, a1.imem_valid_o, a1.dmem_ready_o, a1.dmem_rdata_o,
              a1.dmem_valid_o, a1.mem_en_o, a1.mem_we_o, a1.mem_addr_o, a1.mem_wdata_o, a1.mem_be_o};
        tests++; if (v2 !== '0) begin fails++; $display("FAIL reset_lat2: outputs %h, expected 0", v2); end
        tests++; if (v4 !== '0) begin fails++; $display("FAIL reset_lat4: outputs %h, expected 0", v4); end
        tests++; if (v1 !== '0) begin fails++; $display("FAIL reset_lat1: outputs %h, expected 0", v1); end
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_read;
        a2.imem_req_i = 1; a2.imem_addr_i = 32'h100; a2.mem_rdata_i = 32'hBAD00000; #1;
        tests++;
        if ({a2.imem_ready_o, a2.dmem_ready_o} !== 2'b10) begin
            fails++; $display("FAIL sr_ready: {i,d}=%b, expected 10", {a2.imem_ready_o, a2.dmem_ready_o});
        end
        tick(); a2.imem_req_i = 0; a2.imem_addr_i = '0; #1;
        tests++;
        if ({a2.mem_en_o, a2.mem_we_o, a2.mem_addr_o} !== {1'b1, 1'b0, 32'h100}) begin
            fails++; $display("FAIL sr_issue: en/we/addr=%h, expected %h",
                              {a2.mem_en_o, a2.mem_we_o, a2.mem_addr_o}, {1'b1, 1'b0, 32'h100});
        end
        tick(); a2.mem_rdata_i = 32'hBAD00002; #1;
        tests++;
        if ({a2.mem_en_o, a2.imem_valid_o} !== 2'b00) begin
            fails++; $display("FAIL sr_c2: en,valid=%b, expected 00", {a2.mem_en_o, a2.imem_valid_o});
        end
        tick(); a2.mem_rdata_i = 32'hDEADBEEF; #1;
        tests++;
        if (a2.imem_valid_o !== 1'b0) begin
            fails++; $display("FAIL sr_c3: valid=%b, expected 0", a2.imem_valid_o);
        end
        tick(); a2.mem_rdata_i = 32'hBAD00004; #1;
        tests++;
        if ({a2.imem_valid_o, a2.dmem_valid_o, a2.imem_rdata_o} !== {2'b10, 32'hDEADBEEF}) begin
            fails++; $display("FAIL sr_resp: iv,dv,rdata=%h, expected %h",
                              {a2.imem_valid_o, a2.dmem_valid_o, a2.imem_rdata_o}, {2'b10, 32'hDEADBEEF});
        end
        tick(); #1;
        tests++;
        if ({a2.imem_valid_o, a2.imem_rdata_o} !== {1'b0, 32'hDEADBEEF}) begin
            fails++; $display("FAIL sr_hold: valid,rdata=%h, expected %h",
                              {a2.imem_valid_o, a2.imem_rdata_o}, {1'b0, 32'hDEADBEEF});
        end
        tick();
    endtask

    task automatic test_simultaneous;
        rst = 1'b1; #2; rst = 1'b0;
        tick();
        a2.dmem_req_i = 1; a2.dmem_we_i = 0; a2.dmem_addr_i = 32'h40;
        a2.imem_req_i = 1; a2.imem_addr_i = 32'h200; a2.mem_rdata_i = '0; #1;
        tests++;
        if ({a2.dmem_ready_o, a2.imem_ready_o} !== 2'b10) begin
            fails++; $display("FAIL sim_first: {d,i}=%b, expected 10", {a2.dmem_ready_o, a2.imem_ready_o});
        end
        tick(); a2.dmem_req_i = 0; #1;
        tests++;
        if ({a2.mem_en_o, a2.mem_we_o, a2.imem_ready_o, a2.mem_addr_o} !== {3'b100, 32'h40}) begin
            fails++; $display("FAIL sim_d_issue: got %h, expected %h",
                              {a2.mem_en_o, a2.mem_we_o, a2.imem_ready_o, a2.mem_addr_o}, {3'b100, 32'h40});
        end
        tick(); tick(); a2.mem_rdata_i = 32'hD0D0D0D0; #1;
        tick(); a2.mem_rdata_i = '0; #1;
        tests++;
        if ({a2.dmem_valid_o, a2.imem_valid_o, a2.imem_ready_o, a2.dmem_rdata_o} !== {3'b100, 32'hD0D0D0D0}) begin
            fails++; $display("FAIL sim_d_resp: got %h, expected %h",
                              {a2.dmem_valid_o, a2.imem_valid_o, a2.imem_ready_o, a2.dmem_rdata_o},
                              {3'b100, 32'hD0D0D0D0});
        end
        tick(); #1;
        tests++;
        if ({a2.imem_ready_o, a2.dmem_ready_o} !== 2'b10) begin
            fails++; $display("FAIL sim_second: {i,d}=%b, expected 10", {a2.imem_ready_o, a2.dmem_ready_o});
        end
        tick(); a2.imem_req_i = 0; #1;
        tests++;
        if ({a2.mem_en_o, a2.mem_addr_o} !== {1'b1, 32'h200}) begin
            fails++; $display("FAIL sim_i_issue: got %h, expected %h", {a2.mem_en_o, a2.mem_addr_o}, {1'b1, 32'h200});
        end
        tick(); tick(); a2.mem_rdata_i = 32'h1A1A1A1A; #1;
        tick(); a2.mem_rdata_i = '0; #1;
        tests++;
        if ({a2.imem_valid_o, a2.dmem_valid_o, a2.imem_rdata_o, a2.dmem_rdata_o} !==
            {2'b10, 32'h1A1A1A1A, 32'hD0D0D0D0}) begin
            fails++; $display("FAIL sim_i_resp: got %h, expected %h",
                              {a2.imem_valid_o, a2.dmem_valid_o, a2.imem_rdata_o, a2.dmem_rdata_o},
                              {2'b10, 32'h1A1A1A1A, 32'hD0D0D0D0});
        end
        tick();
    endtask

    task automatic test_held_conflict;
        int   n;
        logic gd [4];
        int   gc [4];
        n = 0;
        for (int k = 0; k < 4; k++) begin gd[k] = 1'b0; gc[k] = -1; end
        a2.dmem_req_i = 1; a2.dmem_we_i = 0; a2.dmem_addr_i = 32'h44;
        a2.imem_req_i = 1; a2.imem_addr_i = 32'h204; a2.mem_rdata_i = 32'hC0FFEE00;
        for (int c = 0; c < 26; c++) begin
            if (n == 4) begin a2.dmem_req_i = 0; a2.imem_req_i = 0; end
            #1;
            if (n < 4 && (a2.dmem_ready_o || a2.imem_ready_o)) begin
                tests++;
                if (a2.dmem_ready_o && a2.imem_ready_o) begin
                    fails++; $display("FAIL hc_onehot: both readys high at cycle %0d", c);
                end
                gd[n] = a2.dmem_ready_o; gc[n] = c; n++;
            end
            tick();
        end
        tests++;
        if (n != 4) begin fails++; $display("FAIL hc_count: %0d grants, expected 4", n); end
        for (int k = 0; k < n; k++) begin
            tests++;
            if (gd[k] !== ((k % 2) == 0)) begin
                fails++; $display("FAIL hc_order: grant %0d data=%b, expected %b", k, gd[k], ((k % 2) == 0));
            end
            tests++;
            if (gc[k] != 5 * k) begin
                fails++; $display("FAIL hc_cycle: grant %0d at cycle %0d, expected %0d", k, gc[k], 5 * k);
            end
        end
    endtask

    task automatic test_write;
        a2.dmem_req_i = 1; a2.dmem_we_i = 1; a2.dmem_addr_i = 32'h20;
        a2.dmem_wdata_i = 32'h11223344; a2.dmem_be_i = 4'b0011; a2.mem_rdata_i = 32'h55555555; #1;
        tests++;
        if (a2.dmem_ready_o !== 1'b1) begin fails++; $display("FAIL wr_ready: got %b, expected 1", a2.dmem_ready_o); end
        tick(); #1;
        tests++;
        if ({a2.mem_en_o, a2.mem_we_o, a2.dmem_ready_o, a2.mem_be_o, a2.mem_addr_o, a2.mem_wdata_o} !==
            {3'b110, 4'b0011, 32'h20, 32'h11223344}) begin
            fails++; $display("FAIL wr_issue: got %h, expected %h",
                              {a2.mem_en_o, a2.mem_we_o, a2.dmem_ready_o, a2.mem_be_o, a2.mem_addr_o, a2.mem_wdata_o},
                              {3'b110, 4'b0011, 32'h20, 32'h11223344});
        end
        tick(); #1;
        tests++;
        if ({a2.dmem_valid_o, a2.imem_valid_o, a2.mem_en_o, a2.dmem_rdata_o} !== {3'b100, 32'hC0FFEE00}) begin
            fails++; $display("FAIL wr_resp: got %h, expected %h",
                              {a2.dmem_valid_o, a2.imem_valid_o, a2.mem_en_o, a2.dmem_rdata_o}, {3'b100, 32'hC0FFEE00});
        end
        tick(); #1;
        tests++;
        if ({a2.dmem_ready_o, a2.dmem_valid_o} !== 2'b10) begin
            fails++; $display("FAIL wr_b2b: ready,valid=%b, expected 10", {a2.dmem_ready_o, a2.dmem_valid_o});
        end
        tick(); a2.dmem_req_i = 0; a2.dmem_we_i = 0; #1;
        tick(); #1;
        tests++;
        if ({a2.dmem_valid_o, a2.dmem_rdata_o} !== {1'b1, 32'hC0FFEE00}) begin
            fails++; $display("FAIL wr_resp2: got %h, expected %h", {a2.dmem_valid_o, a2.dmem_rdata_o}, {1'b1, 32'hC0FFEE00});
        end
        tick();
    endtask

    task automatic test_reset_wait;
        for (int c = 0; c < 8; c++) begin
            a4.imem_req_i = (c == 0); a4.imem_addr_i = 32'h300;
            a4.mem_rdata_i = (c == 5) ? 32'h44444444 : 32'hBAD40000 + 32'(c); #1;
            tests++;
            if (a4.imem_valid_o !== (c == 6)) begin
                fails++; $display("FAIL rw_pre_valid: cycle %0d valid=%b, expected %b", c, a4.imem_valid_o, (c == 6));
            end
            if (c == 6) begin
                tests++;
                if (a4.imem_rdata_o !== 32'h44444444) begin
                    fails++; $display("FAIL rw_pre_data: got %h, expected 44444444", a4.imem_rdata_o);
                end
            end
            tick();
        end
        a4.imem_req_i = 1; a4.imem_addr_i = 32'h304; #1;
        tick(); a4.imem_req_i = 0; #1;
        tick(); tick();
        rst = 1'b1; #1;
        tests++;
        if ({a4.imem_ready_o, a4.imem_rdata_o, a4.imem_valid_o, a4.dmem_ready_o, a4.dmem_rdata_o,
             a4.dmem_valid_o, a4.mem_en_o, a4.mem_we_o, a4.mem_addr_o, a4.mem_wdata_o, a4.mem_be_o} !== '0) begin
            fails++; $display("FAIL rw_abort: irdata=%h ivalid=%b en=%b, expected all 0",
                              a4.imem_rdata_o, a4.imem_valid_o, a4.mem_en_o);
        end
        tick(); tick();
        rst = 1'b0;
        a4.mem_rdata_i = 32'h99999999;
        for (int c = 0; c < 6; c++) begin
            #1;
            tests++;
            if ({a4.imem_valid_o, a4.imem_rdata_o} !== 33'h0) begin
                fails++; $display("FAIL rw_no_pulse: cycle %0d valid,rdata=%h, expected 0", c, {a4.imem_valid_o, a4.imem_rdata_o});
            end
            tick();
        end
        for (int c = 0; c < 8; c++) begin
            a4.imem_req_i = (c == 0); a4.imem_addr_i = 32'h308;
            a4.mem_rdata_i = (c == 5) ? 32'h77777777 : 32'hBAD70000 + 32'(c); #1;
            if (c == 1) begin
                tests++;
                if ({a4.mem_en_o, a4.mem_addr_o} !== {1'b1, 32'h308}) begin
                    fails++; $display("FAIL rw_post_issue: got %h, expected %h", {a4.mem_en_o, a4.mem_addr_o}, {1'b1, 32'h308});
                end
            end
            if (c == 6) begin
                tests++;
                if ({a4.imem_valid_o, a4.imem_rdata_o} !== {1'b1, 32'h77777777}) begin
                    fails++; $display("FAIL rw_post_resp: got %h, expected %h", {a4.imem_valid_o, a4.imem_rdata_o}, {1'b1, 32'h77777777});
                end
            end
            tick();
        end
    endtask

    task automatic test_min_latency;
        for (int c = 0; c < 9; c++) begin
            a1.imem_req_i = (c <= 4); a1.imem_addr_i = 32'h80;
            a1.mem_rdata_i = (c == 2) ? 32'h01010101 : (c == 6) ? 32'h02020202 : 32'hBADBAD00 + 32'(c); #1;
            tests++;
            if (a1.imem_ready_o !== (c == 0 || c == 4)) begin
                fails++; $display("FAIL ml_ready: cycle %0d ready=%b, expected %b", c, a1.imem_ready_o, (c == 0 || c == 4));
            end
            tests++;
            if (a1.imem_valid_o !== (c == 3 || c == 7)) begin
                fails++; $display("FAIL ml_valid: cycle %0d valid=%b, expected %b", c, a1.imem_valid_o, (c == 3 || c == 7));
            end
            if (c == 3 || c == 7) begin
                tests++;
                if (a1.imem_rdata_o !== ((c == 3) ? 32'h01010101 : 32'h02020202)) begin
                    fails++; $display("FAIL ml_data: cycle %0d got %h, expected %h", c, a1.imem_rdata_o,
                                      ((c == 3) ? 32'h01010101 : 32'h02020202));
                end
            end
            tick();
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_single_read();
        test_simultaneous();
        test_held_conflict();
        test_write();
        test_reset_wait();
        test_min_latency();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one single-port synchronous data/instruction memory between the fetch path (instruction port) and the writeback stage (data port). Sits between the fetch/writeback stages and the memory macro. It accepts one request at a time, drives the memory for one cycle, waits a fixed read latency, then returns data with a one-cycle valid pulse. Conflicts are resolved by data-first priority, alternating on back-to-back conflicts.

## Interface
- LATENCY, 2, memory read latency in cycles from the enable cycle to data on mem_rdata_i; legal range 1..7
- ADDR_W, 32, address width
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- imem_req_i  in  1  instruction read request; held with its address until accepted
- imem_addr_i  in  ADDR_W  instruction address
- imem_ready_o  out  1  instruction request accepted this cycle
- imem_rdata_o  out  32  instruction read data; holds its value between responses
- imem_valid_o  out  1  one-cycle pulse: imem_rdata_o is valid
- dmem_req_i  in  1  data request; held with all of its fields until accepted
- dmem_we_i  in  1  1 = write, 0 = read
- dmem_addr_i  in  ADDR_W  data address
- dmem_wdata_i  in  32  write data
- dmem_be_i  in  4  write byte enables
- dmem_ready_o  out  1  data request accepted this cycle
- dmem_rdata_o  out  32  data read data; holds its value between responses
- dmem_valid_o  out  1  one-cycle pulse: read data valid, or write complete
- mem_en_o, mem_we_o  out  1 each  memory enable and write enable
- mem_addr_o  out  ADDR_W  memory address
- mem_wdata_o  out  32  memory write data
- mem_be_o  out  4  memory byte enables
- mem_rdata_i  in  32  memory read data

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- **Grant (combinational, IDLE only).**
  - gnt_d = dmem_req_i & (~imem_req_i | last_gnt==I).
  - gnt_i = imem_req_i & ~gnt_d.
  - dmem_ready_o = (state==IDLE) & gnt_d; imem_ready_o = (state==IDLE) & gnt_i.
  - Both readys are 0 outside IDLE.
- **Accept.** On req & ready:
  - register the owner, address, we, wdata and be;
  - update last_gnt;
  - go to ISSUE.
- **ISSUE** (1 cycle).
  - mem_en_o=1, mem_we_o = we, and the mem_* buses carry the registered fields.
  - mem_we_o is 1 only when the owner is D and it is a write.
  - A write goes to RESP.
  - A read loads cnt = LATENCY and goes to WAIT.
- **WAIT.**
  - mem_en_o=0.
  - cnt decrements each cycle.
  - In the cycle where cnt==1, mem_rdata_i is captured into the owner's rdata register and the state goes to RESP.
  - cnt is 3 bits wide.
- **RESP** (1 cycle).
  - The owner's valid_o is 1.
  - For a write, dmem_valid_o=1 and dmem_rdata_o is unchanged.
  - Next state is IDLE.
- Only the owner's valid and rdata change; the other port is untouched.
- **Reset values.**
  - All outputs 0; state IDLE; cnt 0.
  - last_gnt=I, so the first conflict goes to data.
- **Reset mid-transaction.** Aborts immediately and asynchronously: no valid pulse, rdata cleared to 0, mem_en_o falls with reset.

## Timing
- Acceptance edge E0 = the end of the cycle with req & ready (cycle 0).
- Read: cycle 1 ISSUE; mem_rdata_i is sampled at the end of cycle 1+LATENCY; valid_o is high in cycle 2+LATENCY; the next acceptance is possible in cycle 3+LATENCY.
- Write: cycle 1 ISSUE with mem_we_o=1; dmem_valid_o in cycle 2; the next acceptance is possible in cycle 3.
- Read throughput is one per LATENCY+3 cycles; write throughput is one per 3 cycles.
- A requester must hold req and its fields stable until ready; dropping req before ready cancels the request with no side effect.
- Conflict sequence with both requests held continuously: D, I, D, I, … With only one requester active, it is granted every time.

## Structure
- Shared package mem_arb_pkg:
  - state enum (IDLE, ISSUE, WAIT, RESP);
  - owner encoding (OWN_I=0, OWN_D=1);
  - localparam CNT_W=3.
- One sub-module, arb_rr2: a 2-requester grant with a last-winner register. Inputs are clk, reset, two requests and an advance strobe; outputs are two one-hot grants.

## Test plan
- **Single instruction read:** LATENCY=2; imem_req_i at addr 0x100 with mem_rdata_i=0xDEADBEEF in cycle 3 → mem_en_o in cycle 1 with mem_addr_o=0x100; imem_valid_o only in cycle 4 with imem_rdata_o=0xDEADBEEF.
- **Simultaneous requests after reset:** both raised → dmem granted first and imem second (imem_ready_o in the IDLE cycle after the data RESP); valid pulses follow the same order.
- **Held conflict:** both requests held for 4 transactions → grant order D, I, D, I; no port starved.
- **Data write:** dmem_we_i=1, addr 0x20, wdata 0x11223344, be 0b0011 → in cycle 1 mem_we_o=1 and mem_be_o=0b0011; dmem_valid_o in cycle 2; dmem_rdata_o unchanged.
- **Reset during WAIT:** LATENCY=4, reset asserted in cycle 3 → all outputs 0 immediately; no valid pulse; a fresh imem request after release is served normally.
- **Minimum latency:** LATENCY=1 read → valid in cycle 3; two back-to-back reads accepted at cycles 0 and 4.
